// File: rtl/mul_if.sv
// Handshake bundle between the core control FSM and the multiply sequencer.
// The master issues operations; the slave reports results.
interface mul_if #(
    parameter int XLEN = 32
);
    logic            mul_valid;
    logic [1:0]      mul_op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] rd;
    logic            mul_ready;
    logic            busy;

    modport master (
        output mul_valid, mul_op, rs1, rs2,
        input  rd, mul_ready, busy
    );

    modport slave (
        input  mul_valid, mul_op, rs1, rs2,
        output rd, mul_ready, busy
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Radix-2 shift-add sequencer for RV32M MUL/MULH/MULHSU/MULHU.
// Multiplies magnitudes over XLEN steps, then applies the sign fix.
module mul_seq_ctrl #(
    parameter int XLEN = 32
) (
    input logic  clk,
    input logic  resetn,
    mul_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        op_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   rd_q;
    logic [2*XLEN-1:0] prod_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q;

    logic              neg1, neg2;
    logic [XLEN-1:0]   abs1, abs2;
    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod_fix;
    logic              last;

    // rs1 is signed unless MULHU; rs2 is signed only for MUL/MULH
    always_comb begin
        neg1 = (bus.mul_op != 2'b11) && bus.rs1[XLEN-1];
        neg2 = !bus.mul_op[1] && bus.rs2[XLEN-1];
        abs1 = neg1 ? -bus.rs1 : bus.rs1;
        abs2 = neg2 ? -bus.rs2 : bus.rs2;
    end

    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        sum      = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, addend};
        prod_fix = neg_q ? -prod_q : prod_q;
        last     = (cnt_q == CW'(XLEN - 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.mul_valid) state_d = S_CALC;
            S_CALC:  if (last) state_d = S_SIGN;
            S_SIGN:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rd_q     <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.mul_valid) begin
                        op_q     <= bus.mul_op;
                        mcand_q  <= abs1;
                        mplier_q <= abs2;
                        neg_q    <= neg1 ^ neg2;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                    end
                end
                // carry out of the add lands in the top bit after the shift
                S_CALC: begin
                    prod_q   <= {sum, prod_q[XLEN-1:1]};
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                end
                S_SIGN: begin
                    prod_q <= prod_fix;
                    rd_q   <= (op_q == 2'b00) ? prod_fix[XLEN-1:0]
                                              : prod_fix[2*XLEN-1:XLEN];
                end
                default: ;
            endcase
        end
    end

    assign bus.rd        = rd_q;
    assign bus.mul_ready = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Iterative radix-2 shift-add multiply sequencer for the RV32M MUL/MULH/MULHSU/MULHU datapath of the multicycle core.
- Accepts a decoded multiply op plus operands from the main control FSM and runs XLEN add/shift steps.
- Applies sign correction, then returns the selected 32-bit half with a one-cycle ready pulse.
- Replaces a single-cycle DSP multiply on small FPGAs.

Parameters:
XLEN, 32, operand/result width; product register is 2*XLEN bits, iteration counter is $clog2(XLEN)+1 bits

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  synchronous active-low reset
mul_valid  input  1  request from control FSM; sampled only in IDLE
mul_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (same as funct3[1:0])
rs1  input  XLEN  multiplicand, latched at accept
rs2  input  XLEN  multiplier, latched at accept
rd  output  XLEN  result; valid while mul_ready=1, held until next accept
mul_ready  output  1  one-cycle completion pulse
busy  output  1  high in CALC, SIGN, DONE

Behaviour:
- Reset (resetn=0 at clk edge, any state): state=IDLE, mul_ready=0, rd=0, busy=0, counter=0, product=0.
- Sign rules: rs1 signed for MUL/MULH/MULHSU; rs2 signed for MUL/MULH only; MULHU both unsigned.
- States:
  - IDLE: if mul_valid=1, latch op, |rs1| and |rs2| (two's-complement negate when signed and MSB=1), neg_flag = sign1 XOR sign2 (signed operands only), clear product and counter, go CALC.
  - CALC: each cycle, if multiplier LSB=1, add multiplicand into product upper half with carry; then shift {carry,product} right 1 and shift multiplier right 1. Counter increments; after XLEN cycles go SIGN.
  - SIGN: if neg_flag, product = two's-complement negation of the 2*XLEN product. Select product[XLEN-1:0] for MUL, else product[2*XLEN-1:XLEN]. Register into rd. Go DONE.
  - DONE: mul_ready=1 for exactly this cycle, go IDLE.
- Latency: accept at edge T; CALC T+1..T+XLEN; SIGN T+XLEN+1; mul_ready=1 during cycle T+XLEN+2 (34 cycles for XLEN=32). Fixed; no early-out on zero operands.
- Back-to-back: a new request is accepted in IDLE no earlier than the cycle after DONE. Control FSM must drop mul_valid on seeing mul_ready, otherwise a re-issue occurs; this is legal and is not an error.
- Changes to rs1/rs2/mul_op/mul_valid after accept are ignored. The operation always completes and pulses mul_ready.
- abs(0x80000000) = 0x80000000 treated as unsigned; results are exact for all operand pairs including the most negative value.
- Reset mid-operation: aborts immediately, with no mul_ready pulse afterwards.
- rd holds its last value through IDLE until overwritten in the next SIGN.

Test Plan:
- Reset, then MUL rs1=7, rs2=0xFFFFFFFD -> rd=0xFFFFFFEB, mul_ready high only at accept+34, busy high accept+1..accept+34.
- MULH rs1=rs2=0x80000000 -> rd=0x40000000; MUL with same operands -> rd=0x00000000.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> rd=0xFFFFFFFF; MULHU with same operands -> rd=0xFFFFFFFE.
- MULHU rs1=0, rs2=0xFFFFFFFF -> rd=0 after the full 34 cycles; toggling rs1/rs2/mul_op during CALC leaves the result unchanged.
- mul_valid held high across completion -> second op accepted in the cycle after DONE, second mul_ready at +35 cycles after the first; random 10k-op regression against a 64-bit reference model for all four ops.
- resetn low during CALC (accept+10) -> next edge state=IDLE, rd=0, mul_ready never asserts; a subsequent MUL 3*5 -> rd=15.
